// File: rtl/dout_drain_pkg.sv
// Shared definitions for the DDR2 data-out drain controller:
// state encoding and the width helpers used to size the lane logic.
package dout_drain_pkg;

    // Controller states. The pop cycle (RD) is a transient merged into the
    // IDLE->WAIT and SEND->WAIT edges, so it has no encoding of its own.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SEND = 2'd2
    } drain_state_t;

    // Ceiling log2 with a floor of 1, so that a single-lane build still gets
    // a one-bit lane counter.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

    // Number of output lanes carried by one FIFO word.
    function automatic int div_of(input int di_width, input int do_width);
        return di_width / do_width;
    endfunction

endpackage

// File: rtl/dout_lane_shift.sv
// Holding register and lane selector for the drain controller.
// A load captures a full FIFO word and presents its first lane on the next
// cycle; each advance presents the following lane. LO_FIRST chooses whether
// the least- or most-significant lane leaves first.
module dout_lane_shift
    import dout_drain_pkg::*;
#(
    parameter int DI_WIDTH = 64,
    parameter int DO_WIDTH = 32,
    parameter bit LO_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                advance,
    input  logic [DI_WIDTH-1:0] din,
    output logic [DO_WIDTH-1:0] data_out,
    output logic                last_lane
);

    localparam int DIV    = div_of(DI_WIDTH, DO_WIDTH);
    localparam int LANE_W = clog2_min1(DIV);

    logic [DI_WIDTH-1:0] hold_r;
    logic [LANE_W-1:0]   lane_r;
    logic [LANE_W-1:0]   next_lane_s;
    logic [DO_WIDTH-1:0] data_out_r;
    logic [DO_WIDTH-1:0] hold_lane_s [DIV];
    logic [DO_WIDTH-1:0] din_lane_s  [DIV];
    logic                last_lane_s;

    // Reorder both the incoming word and the held word into send order, so
    // that index 0 is always the first lane to leave.
    for (genvar g = 0; g < DIV; g++) begin : g_lane
        localparam int PHYS = (LO_FIRST != 1'b0) ? g : (DIV - 1 - g);
        assign hold_lane_s[g] = hold_r[PHYS*DO_WIDTH +: DO_WIDTH];
        assign din_lane_s[g]  = din[PHYS*DO_WIDTH +: DO_WIDTH];
    end

    assign next_lane_s = lane_r + LANE_W'(1'b1);
    assign last_lane_s = (lane_r == LANE_W'(DIV - 1));

    // Capture a new word, or step to the next lane of the held word
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_r     <= {DI_WIDTH{1'b0}};
            lane_r     <= {LANE_W{1'b0}};
            data_out_r <= {DO_WIDTH{1'b0}};
        end else if (load) begin
            hold_r     <= din;
            lane_r     <= {LANE_W{1'b0}};
            data_out_r <= din_lane_s[0];
        end else if (advance && !last_lane_s) begin
            hold_r     <= hold_r;
            lane_r     <= next_lane_s;
            data_out_r <= hold_lane_s[next_lane_s];
        end else begin
            hold_r     <= hold_r;
            lane_r     <= lane_r;
            data_out_r <= data_out_r;
        end
    end

    assign data_out  = data_out_r;
    assign last_lane = last_lane_s;

endmodule

// File: rtl/dout_drain_ctrl.sv
// Read-side controller for the 64->32 output FIFO of the DDR2 data-out path.
// Pops one FIFO word at a time, splits it into lanes and hands them to the
// board-side consumer over valid/ready with full backpressure. At most one
// word is ever in flight.
// Optional feature: define DOUT_DRAIN_CNT_EN to add the 32-bit word_cnt port
// counting every accepted output lane.
module dout_drain_ctrl
    import dout_drain_pkg::*;
#(
    parameter int DI_WIDTH = 64,
    parameter int DO_WIDTH = 32,
    parameter bit LO_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [DI_WIDTH-1:0] fifo_dout,
    input  logic                fifo_valid,
    output logic [DO_WIDTH-1:0] data_out,
    output logic                dout_vd,
    input  logic                dout_rdy,
    output logic                busy,
    output logic                err_unexp
`ifdef DOUT_DRAIN_CNT_EN
    ,
    output logic [31:0]         word_cnt
`endif
);

    if ((DI_WIDTH % DO_WIDTH) != 0) begin : g_bad_width
        $error("dout_drain_ctrl: DI_WIDTH must be an integer multiple of DO_WIDTH");
    end

    drain_state_t state_r;
    drain_state_t state_nxt_s;
    logic         dout_vd_r;
    logic         dout_vd_nxt_s;
    logic         busy_r;
    logic         err_unexp_r;
    logic         rd_en_s;
    logic         load_s;
    logic         advance_s;
    logic         accept_s;
    logic         last_lane_s;

    assign accept_s = dout_vd_r & dout_rdy;

    // Next state, pop strobe and lane-shifter control
    always_comb begin
        state_nxt_s   = state_r;
        dout_vd_nxt_s = dout_vd_r;
        rd_en_s       = 1'b0;
        load_s        = 1'b0;
        advance_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    rd_en_s     = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // No timeout: the FIFO is guaranteed to answer a pop.
                if (fifo_valid) begin
                    load_s        = 1'b1;
                    dout_vd_nxt_s = 1'b1;
                    state_nxt_s   = ST_SEND;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (!accept_s) begin
                    state_nxt_s = ST_SEND;
                end else if (!last_lane_s) begin
                    advance_s     = 1'b1;
                    dout_vd_nxt_s = 1'b1;
                    state_nxt_s   = ST_SEND;
                end else if (enable && !fifo_empty) begin
                    // Back-to-back pop on the final lane's handshake.
                    rd_en_s       = 1'b1;
                    dout_vd_nxt_s = 1'b0;
                    state_nxt_s   = ST_WAIT;
                end else begin
                    dout_vd_nxt_s = 1'b0;
                    state_nxt_s   = ST_IDLE;
                end
            end
            default: begin
                dout_vd_nxt_s = 1'b0;
                state_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // State, output-valid, busy and sticky unexpected-data flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            dout_vd_r   <= 1'b0;
            busy_r      <= 1'b0;
            err_unexp_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            dout_vd_r   <= dout_vd_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            err_unexp_r <= err_unexp_r | (fifo_valid & (state_r != ST_WAIT));
        end
    end

    dout_lane_shift #(
        .DI_WIDTH (DI_WIDTH),
        .DO_WIDTH (DO_WIDTH),
        .LO_FIRST (LO_FIRST)
    ) u_lane_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .advance   (advance_s),
        .din       (fifo_dout),
        .data_out  (data_out),
        .last_lane (last_lane_s)
    );

    // The pop must land in the same cycle as the last-lane handshake, so it is
    // decoded combinationally; reset masks it so no pop escapes during reset.
    assign fifo_rd_en = rd_en_s & ~reset;
    assign dout_vd    = dout_vd_r;
    assign busy       = busy_r;
    assign err_unexp  = err_unexp_r;

`ifdef DOUT_DRAIN_CNT_EN
    logic [31:0] word_cnt_r;

    // Count accepted output lanes; wraps through zero at 32 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_r <= 32'd0;
        end else if (accept_s) begin
            word_cnt_r <= word_cnt_r + 32'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign word_cnt = word_cnt_r;
`endif

endmodule

// File: tb/tb_dout_drain_ctrl.sv
// Bench for dout_drain_ctrl: a queue-based FIFO model feeds the DUT, and a
// lane-level model (queue of lanes still owed to the consumer) predicts the
// pop strobe, valid, data, busy and error flag every cycle. Directed tests
// then pin the model with hand-computed lane values.
module tb_dout_drain_ctrl;

    localparam int DI_W = 64;
    localparam int DO_W = 32;
    localparam int DIV  = DI_W / DO_W;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            fifo_empty;
    logic            fifo_rd_en;
    logic [DI_W-1:0] fifo_dout;
    logic            fifo_valid;
    logic [DO_W-1:0] data_out;
    logic            dout_vd;
    logic            dout_rdy;
    logic            busy;
    logic            err_unexp;
`ifdef DOUT_DRAIN_CNT_EN
    logic [31:0]     word_cnt;
`endif

    dout_drain_ctrl #(
        .DI_WIDTH (DI_W),
        .DO_WIDTH (DO_W),
        .LO_FIRST (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_valid (fifo_valid),
        .data_out   (data_out),
        .dout_vd    (dout_vd),
        .dout_rdy   (dout_rdy),
        .busy       (busy),
        .err_unexp  (err_unexp)
`ifdef DOUT_DRAIN_CNT_EN
        ,
        .word_cnt   (word_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DI_W-1:0] fq[$];        // FIFO contents
    logic [DO_W-1:0] exp_q[$];     // lanes popped but not yet accepted
    logic [DO_W-1:0] lane_log[$];  // every accepted lane, in order
    logic [DI_W-1:0] pend_word;
    bit              pop_pend;
    bit              inj_valid;
    bit              err_model;
    bit              last_vd;
    int              since_pop;
    int              rst_seen;
    int              acc_cnt;
    int              pop_cnt;
    int              n_cmp;
    int              n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock cycle: present FIFO response, check outputs, update model.
    task automatic tick();
        bit acc;
        bit exp_pop;
        bit exp_vd;
        if (since_pop < 100) since_pop++;
        if (inj_valid) begin
            fifo_valid = 1'b1;
            fifo_dout  = 64'hDEAD_BEEF_0BAD_CAFE;
        end else if (pop_pend) begin
            fifo_valid = 1'b1;
            fifo_dout  = pend_word;
        end else begin
            fifo_valid = 1'b0;
            fifo_dout  = 64'h0;
        end
        pop_pend   = 1'b0;
        fifo_empty = (fq.size() == 0);
        #1;
        if (reset) begin
            chk("rst_rd_en", fifo_rd_en, 1'b0);
            if (rst_seen >= 1) begin
                chk("rst_data_out", data_out, 32'h0);
                chk("rst_dout_vd", dout_vd, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_err", err_unexp, 1'b0);
`ifdef DOUT_DRAIN_CNT_EN
                chk("rst_word_cnt", word_cnt, 32'h0);
`endif
            end
            rst_seen++;
            last_vd = 1'b0;
        end else begin
            acc     = dout_vd && dout_rdy;
            exp_pop = enable && !fifo_empty &&
                      (exp_q.size() == 0 || (exp_q.size() == 1 && acc));
            exp_vd  = (exp_q.size() > 0) && (since_pop >= 2);
            chk("fifo_rd_en", fifo_rd_en, exp_pop);
            chk("dout_vd", dout_vd, exp_vd);
            chk("busy", busy, exp_q.size() > 0);
            chk("err_unexp", err_unexp, err_model);
            if (exp_vd) chk("data_out", data_out, exp_q[0]);
`ifdef DOUT_DRAIN_CNT_EN
            chk("word_cnt", word_cnt, acc_cnt);
`endif
            last_vd = dout_vd;
            if (acc) begin
                lane_log.push_back(data_out);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                acc_cnt++;
            end
            if (fifo_rd_en && fq.size() > 0) begin
                pend_word = fq.pop_front();
                pop_pend  = 1'b1;
                since_pop = 0;
                pop_cnt++;
                for (int i = 0; i < DIV; i++) exp_q.push_back(pend_word[i*DO_W +: DO_W]);
            end
            if (inj_valid) err_model = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        fq.delete();
        exp_q.delete();
        pop_pend  = 1'b0;
        since_pop = 100;
        err_model = 1'b0;
        acc_cnt   = 0;
        rst_seen  = 0;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    task automatic wait_vd(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = last_vd;
        end
        chk("wait_vd_bound", seen, 1'b1);
    endtask

    task automatic run_drain(input int budget);
        int n;
        n = 0;
        while (((fq.size() > 0 && enable) || exp_q.size() > 0 || pop_pend) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_bound", n < budget, 1'b1);
    endtask

    initial begin
        int b;
        int p;
        reset      = 1'b1;
        enable     = 1'b0;
        dout_rdy   = 1'b1;
        fifo_valid = 1'b0;
        fifo_dout  = 64'h0;
        fifo_empty = 1'b1;
        inj_valid  = 1'b0;
        n_cmp = 0; n_err = 0; pop_cnt = 0;
        do_reset(3);

        // Single word, LO_FIRST ordering, one pop.
        b = lane_log.size(); p = pop_cnt;
        fq.push_back(64'h1122_3344_5566_7788);
        enable = 1'b1;
        run_drain(20);
        repeat (3) tick();
        chk("t2_lane0", lane_log[b], 32'h5566_7788);
        chk("t2_lane1", lane_log[b+1], 32'h1122_3344);
        chk("t2_pops", pop_cnt - p, 1);

        // Backpressure: hold 10 cycles then release.
        b = lane_log.size(); p = pop_cnt;
        dout_rdy = 1'b0;
        fq.push_back(64'hA5A5_0001_5A5A_0002);
        wait_vd(10);
        repeat (10) tick();
        chk("t3_pops_held", pop_cnt - p, 1);
        dout_rdy = 1'b1;
        run_drain(20);
        chk("t3_lane0", lane_log[b], 32'h5A5A_0002);
        chk("t3_lane1", lane_log[b+1], 32'hA5A5_0001);

        // Stream of 8 words.
        b = lane_log.size(); p = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            fq.push_back({32'hB000_0000 + 32'(2*i + 1), 32'hB000_0000 + 32'(2*i)});
        end
        run_drain(200);
        chk("t4_pops", pop_cnt - p, 8);
        chk("t4_lanes", lane_log.size() - b, 16);
        for (int k = 0; k < 16; k++) chk("t4_lane", lane_log[b+k], 32'hB000_0000 + 32'(k));

        // Enable drop during lane 0.
        b = lane_log.size();
        dout_rdy = 1'b0;
        fq.push_back(64'hCAFE_0001_CAFE_0000);
        fq.push_back(64'hCAFE_0003_CAFE_0002);
        wait_vd(10);
        enable   = 1'b0;
        dout_rdy = 1'b1;
        run_drain(20);
        repeat (3) tick();
        chk("t5_lane0", lane_log[b], 32'hCAFE_0000);
        chk("t5_lane1", lane_log[b+1], 32'hCAFE_0001);
        chk("t5_fifo_left", fq.size(), 1);
        chk("t5_busy", busy, 1'b0);

        // Reset in the middle of SEND.
        enable   = 1'b1;
        dout_rdy = 1'b0;
        wait_vd(10);
        repeat (2) tick();
        do_reset(3);
        enable   = 1'b0;
        dout_rdy = 1'b1;
        repeat (2) tick();

        // Unexpected fifo_valid while idle.
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        tick();
        chk("t6_err_set", err_unexp, 1'b1);
        b = lane_log.size();
        fq.push_back(64'h0BAD_F00D_1234_5678);
        enable = 1'b1;
        run_drain(20);
        repeat (2) tick();
        chk("t6_lane0", lane_log[b], 32'h1234_5678);
        chk("t6_lane1", lane_log[b+1], 32'h0BAD_F00D);
        chk("t6_err_sticky", err_unexp, 1'b1);
`ifdef DOUT_DRAIN_CNT_EN
        chk("t6_word_cnt", word_cnt, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
